adc_capture_ctrl: RTL
=====================

# adc_capture_ctrl

Sequencing controller for the dual-channel 14-bit ADC front end in `sys_top`. It powers the ADC up on request, waits a fixed wake-up time, and arms a level trigger on channel A. After the trigger it captures a programmed number of A/B sample pairs and streams them, packed with their overflow flags, to a downstream valid/ready sink (FIFO or DMA). Between captures it returns the ADC to shutdown.

## Interface
- `WAKE_CYCLES`, default 64: `sys_clk` cycles between `ad_shdna/b` deassertion and arming.
- `LEN_W`, default 16: width of `cfg_len`.
- `DROP_W`, default 8: width of the saturating drop counter.

Ports:
- `sys_clk`  in  1  — single clock; ADC data is synchronous to it.
- `sys_rst_n`  in  1  — asynchronous, active-low reset.
- `cfg_start`  in  1  — one-cycle start pulse; ignored unless IDLE.
- `cfg_abort`  in  1  — one-cycle abort; acts in any state.
- `cfg_len`  in  LEN_W  — sample pairs per capture; sampled at start.
- `cfg_trig_en`  in  1  — 1 = wait for trigger; 0 = capture immediately after wake-up.
- `cfg_trig_level`  in  14  — trigger level, offset-binary; sampled at start.
- `ad_porta_data`, `ad_portb_data`  in  14  — ADC samples.
- `ad_ofa`, `ad_ofb`  in  1  — ADC overflow flags.
- `ad_shdna`, `ad_shdnb`  out  1  — ADC shutdown; high in IDLE.
- `wr_valid`  out  1  — output pair valid.
- `wr_ready`  in  1  — sink ready.
- `wr_data`  out  32  — packed as `{ofa,1'b0,a[13:0],ofb,1'b0,b[13:0]}`.
- `busy`  out  1  — high in every state except IDLE.
- `done`  out  1  — one-cycle pulse at normal completion.
- `ovf_seen`  out  1  — sticky; any captured flag was set; cleared at start.
- `drop_cnt`  out  DROP_W  — saturating count of dropped pairs; cleared at start.

## Operation
- **Reset values:** state IDLE, `ad_shdna/b`=1, all other outputs 0.
- **Input stage:** `ad_*` are registered every cycle in all states.
- **IDLE:**
  - `cfg_start` latches `cfg_len`, `cfg_trig_level` and `cfg_trig_en`.
  - Start clears `ovf_seen` and `drop_cnt`, deasserts shdn and moves to WAKE.
  - If `cfg_len`=0: pulse `done` next cycle, stay IDLE, shdn stays 1.
- **WAKE:** counts WAKE_CYCLES, then goes to ARM.
- **ARM:**
  - With `cfg_trig_en`=0, goes to CAPTURE on the next cycle.
  - Otherwise waits for a rising crossing on registered channel A: previous < level and current >= level (unsigned).
  - The crossing sample is capture slot 0.
- **CAPTURE:**
  - Each cycle is one slot and consumes one registered pair.
  - If the output register is empty, or is being accepted this cycle, the pair is loaded.
  - Otherwise the pair is dropped and `drop_cnt` increments, saturating at all-ones.
  - After `cfg_len` slots, goes to DRAIN.
- **DRAIN:** waits until `wr_valid`=0 or a handshake completes, then pulses `done` and goes to IDLE with shdn=1.
- **Handshake:** while `wr_valid`=1 and `wr_ready`=0, `wr_data` is held stable.
- **Abort:**
  - In any state: IDLE next cycle, `wr_valid` cleared, no `done`, shdn=1.
  - `cfg_abort` together with `cfg_start`: abort wins.
- **Overflow:** `ovf_seen` sets when a loaded pair has `ofa` or `ofb` set. Dropped pairs do not set it.

## Timing
- Sample on ADC pins at edge k appears on `wr_data` with `wr_valid` after edge k+2, when the sink was ready.
- Start pulse at edge s: shdn low after s+1; ARM entered after s+1+WAKE_CYCLES.
- `done` asserts the cycle after the final handshake. With `wr_ready` held at 1, that is `cfg_len`+2 cycles after the trigger sample reaches the pins.
- Trigger compare uses registered samples only; there is no combinational path from `ad_*` to outputs.

## Configuration
- **`ADC_CAP_OVF_ABORT_EN` defined:**
  - A loaded pair with `ofa|ofb` set ends CAPTURE after that pair and goes to DRAIN.
  - `done` still pulses and `ovf_seen`=1.
- **Undefined:** overflow is only recorded in `wr_data` and `ovf_seen`; capture length is unaffected.

## Structure
- Package `adc_cap_pkg` holds:
  - `ADC_W`=14;
  - the state enum `{IDLE,WAKE,ARM,CAPTURE,DRAIN}`;
  - the `wr_data` pack function and its field positions.
- One sub-module, `adc_trig_det`: holds the previous-sample register and the crossing compare, and outputs a one-cycle `trig` pulse. The controller holds the FSM, counters and output register.

## Test plan
- **Free-run:** `cfg_trig_en`=0, `cfg_len`=8, WAKE_CYCLES=4, `wr_ready`=1 → exactly 8 `wr_valid` beats with consecutive samples, then one `done` pulse; shdn=1 before and after.
- **Trigger:** 13-sample sine around 0x2000, amplitude 0x1FFF, level 0x2000, `cfg_len`=13 → first beat is the first sample >= 0x2000 following one < 0x2000; 13 beats.
- **Back-pressure:** `wr_ready` low for 3 cycles mid-capture, `cfg_len`=10 → `wr_data` stable while stalled, `drop_cnt`=3, 7 beats, `done` once.
- **Abort:** `cfg_abort` in CAPTURE after 2 beats → `wr_valid`=0 next cycle, no `done`, shdn=1; a new start then works normally.
- **Overflow:** `ad_ofa`=1 on slot 4, `cfg_len`=10 → bit 31 set on beat 4 and `ovf_seen`=1. With `ADC_CAP_OVF_ABORT_EN`, exactly 5 beats then `done`.
- **Edge cases:**
  - `cfg_len`=0 → `done` with zero beats, shdn never low.
  - `cfg_start` while busy → ignored.
  - Reset mid-capture → all outputs at reset values.

Source files
------------

// File: rtl/adc_cap_pkg.sv
// Shared definitions for the ADC capture controller: sample width, FSM state
// encoding and the packing of one A/B sample pair into the 32-bit output word.
package adc_cap_pkg;

  localparam int ADC_W   = 14;
  localparam int WORD_W  = 32;

  // Field positions inside wr_data: {ofa, 1'b0, a[13:0], ofb, 1'b0, b[13:0]}
  localparam int OFA_BIT = 31;
  localparam int A_LSB   = 16;
  localparam int OFB_BIT = 15;
  localparam int B_LSB   = 0;

  typedef enum logic [2:0] {
    IDLE,
    WAKE,
    ARM,
    CAPTURE,
    DRAIN
  } cap_state_t;

  // Pack one sample pair with its overflow flags; unused bits stay zero.
  function automatic logic [WORD_W-1:0] pack_pair(
    input logic             ofa,
    input logic [ADC_W-1:0] a,
    input logic             ofb,
    input logic [ADC_W-1:0] b
  );
    logic [WORD_W-1:0] w;
    w                  = '0;
    w[OFA_BIT]         = ofa;
    w[A_LSB +: ADC_W]  = a;
    w[OFB_BIT]         = ofb;
    w[B_LSB +: ADC_W]  = b;
    return w;
  endfunction

endpackage

// File: rtl/adc_trig_det.sv
// Rising-crossing trigger detector for channel A. Compares the registered
// sample against the one before it and emits a one-cycle registered pulse
// aligned with the controller's second pipeline stage.
module adc_trig_det
  import adc_cap_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADC_W-1:0] sample,
  input  logic [ADC_W-1:0] level,
  output logic             trig
);

  logic [ADC_W-1:0] prev;

  // Keep the previous sample and flag prev < level <= current (unsigned).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
      trig <= 1'b0;
    end else begin
      prev <= sample;
      trig <= (prev < level) && (sample >= level);
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Dual-channel ADC capture sequencer: power-up, wake-up wait, optional level
// trigger on channel A, capture of cfg_len A/B pairs into a one-deep
// valid/ready output register, drain, and return to shutdown.
// Build option: define ADC_CAP_OVF_ABORT_EN to end a capture right after a
// loaded pair that carries an overflow flag.
module adc_capture_ctrl
  import adc_cap_pkg::*;
#(
  parameter int WAKE_CYCLES = 64,
  parameter int LEN_W       = 16,
  parameter int DROP_W      = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_trig_en,
  input  logic [ADC_W-1:0]  cfg_trig_level,
  input  logic [ADC_W-1:0]  ad_porta_data,
  input  logic [ADC_W-1:0]  ad_portb_data,
  input  logic              ad_ofa,
  input  logic              ad_ofb,
  output logic              ad_shdna,
  output logic              ad_shdnb,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              ovf_seen,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  cap_state_t        state;
  logic              shdn;
  logic [LEN_W-1:0]  len_q;
  logic [ADC_W-1:0]  level_q;
  logic              trig_en_q;
  logic [WAKE_W-1:0] wake_cnt;
  logic [LEN_W-1:0]  slot_cnt;

  // Two-stage input pipeline; stage 2 lines up with the registered trigger.
  logic [ADC_W-1:0]  s1_a, s1_b, s2_a, s2_b;
  logic              s1_ofa, s1_ofb, s2_ofa, s2_ofb;
  logic              trig;

  // Slot decode
  logic              load_ok;
  logic              slot_ovf;
  logic              ovf_end;
  logic              last_slot;
  logic [31:0]       slot_word;

  assign ad_shdna = shdn;
  assign ad_shdnb = shdn;

  // Register the ADC pins every cycle, regardless of state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the pipeline shifts by exactly one stage.
    if (!sys_rst_n) begin
      s1_a   <= '0;
      s1_b   <= '0;
      s1_ofa <= 1'b0;
      s1_ofb <= 1'b0;
      s2_a   <= '0;
      s2_b   <= '0;
      s2_ofa <= 1'b0;
      s2_ofb <= 1'b0;
    end else begin
      s1_a   <= ad_porta_data;
      s1_b   <= ad_portb_data;
      s1_ofa <= ad_ofa;
      s1_ofb <= ad_ofb;
      s2_a   <= s1_a;
      s2_b   <= s1_b;
      s2_ofa <= s1_ofa;
      s2_ofb <= s1_ofb;
    end
  end

  adc_trig_det u_trig (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .sample (s1_a),
    .level  (level_q),
    .trig   (trig)
  );

  // Work out whether the current slot's pair can be loaded and whether it ends the capture.
  always_comb begin
    // NOTE: each output gets a default first so no path can leave it
    // unassigned and infer a latch.
    load_ok   = 1'b0;
    slot_ovf  = 1'b0;
    ovf_end   = 1'b0;
    last_slot = 1'b0;
    slot_word = '0;

    load_ok   = !wr_valid || wr_ready;
    slot_ovf  = s2_ofa | s2_ofb;
    last_slot = (slot_cnt == len_q - LEN_W'(1));
    slot_word = pack_pair(s2_ofa, s2_a, s2_ofb, s2_b);
`ifdef ADC_CAP_OVF_ABORT_EN
    ovf_end   = load_ok && slot_ovf;
`else
    ovf_end   = 1'b0;
`endif
  end

  // Sequencing FSM with registered outputs, counters and the output register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      shdn      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_valid  <= 1'b0;
      wr_data   <= '0;
      ovf_seen  <= 1'b0;
      drop_cnt  <= '0;
      len_q     <= '0;
      level_q   <= '0;
      trig_en_q <= 1'b0;
      wake_cnt  <= '0;
      slot_cnt  <= '0;
    end else begin
      done <= 1'b0;
      // A completed handshake empties the output register unless a new pair
      // is loaded below; the later assignment in this block takes precedence.
      if (wr_valid && wr_ready) wr_valid <= 1'b0;

      if (cfg_abort) begin
        state    <= IDLE;
        shdn     <= 1'b1;
        busy     <= 1'b0;
        wr_valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (cfg_start) begin
              len_q     <= cfg_len;
              level_q   <= cfg_trig_level;
              trig_en_q <= cfg_trig_en;
              ovf_seen  <= 1'b0;
              drop_cnt  <= '0;
              if (cfg_len == '0) begin
                done <= 1'b1;
              end else begin
                state    <= WAKE;
                shdn     <= 1'b0;
                busy     <= 1'b1;
                wake_cnt <= '0;
              end
            end
          end

          WAKE: begin
            if (wake_cnt == WAKE_LAST) state <= ARM;
            else wake_cnt <= wake_cnt + WAKE_W'(1);
          end

          ARM: begin
            if (!trig_en_q) begin
              state    <= CAPTURE;
              slot_cnt <= '0;
            end else if (trig) begin
              // The crossing sample itself is slot 0; the register is empty here.
              wr_data  <= slot_word;
              wr_valid <= 1'b1;
              if (slot_ovf) ovf_seen <= 1'b1;
              slot_cnt <= LEN_W'(1);
              if (len_q == LEN_W'(1) || ovf_end) state <= DRAIN;
              else state <= CAPTURE;
            end
          end

          CAPTURE: begin
            if (load_ok) begin
              wr_data  <= slot_word;
              wr_valid <= 1'b1;
              if (slot_ovf) ovf_seen <= 1'b1;
            end else if (drop_cnt != '1) begin
              drop_cnt <= drop_cnt + DROP_W'(1);
            end
            if (last_slot || ovf_end) state <= DRAIN;
            else slot_cnt <= slot_cnt + LEN_W'(1);
          end

          DRAIN: begin
            if (!wr_valid || wr_ready) begin
              done     <= 1'b1;
              state    <= IDLE;
              shdn     <= 1'b1;
              busy     <= 1'b0;
              wr_valid <= 1'b0;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
